approx_rca_pipe: RTL
====================

# approx_rca_pipe

Parametrised, two-stage pipelined approximate ripple-carry adder with a valid/ready handshake. A runtime-selectable number of LSB positions uses the approximate full-adder cell; the rest use exact full adders. It is the drop-in successor to the fixed-width combinational approximate adders in the adder library, for streaming datapaths. An optional on-line error monitor accumulates error statistics for area/MSE characterisation.

## Interface
- WIDTH, 16: operand width; must be even and at least 4.
- APPROX_MAX, 4: maximum number of approximate LSB cells; range 1..WIDTH/2.
- KW, $clog2(APPROX_MAX+1): width of the approximation-depth field (derived).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  adder accepts a beat this cycle.
- in_a, in_b  in  WIDTH  operands, unsigned.
- in_k  in  KW  requested approximate LSB count.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH+1  approximate sum, including carry-out.
- out_k  out  KW  effective k used for this beat.
- Present only with ERR_MON_EN: mon_clr in 1; mon_cnt out 32; mon_nz out 32; mon_err_sum out 32; mon_err_sq out 48; mon_err_max out APPROX_MAX.

## Operation
- Effective k is min(in_k, APPROX_MAX), captured with the beat.
- Bits below k use the approximate cell: S = (X|Y)&~Z and Cout = 0. The first cell has Cz = 0, so those bits equal a|b and the carry into bit k is 0.
- Bits k..WIDTH-1 are exact full adders; bit WIDTH of out_sum is the final carry. k = 0 gives the exact a+b.
- Arithmetic identity (verification oracle): out_sum = (a+b) − (a_lo & b_lo), where a_lo and b_lo are the low k bits. The error is always ≥ 0 and < 2^k.
- Stage 1 computes bits [WIDTH/2−1:0] and registers the partial sum, the carry, the upper operand halves and k. Stage 2 computes the upper half and the carry-out.
- Handshake:
  - s1_adv = ~s2_valid | out_ready.
  - in_ready = ~s1_valid | s1_adv.
  - A beat transfers on valid & ready at each interface.
  - No beat is dropped or duplicated, and order is preserved.
- While out_valid & ~out_ready, out_sum and out_k are held stable.

## Timing
- Latency is 2 cycles from input handshake to out_valid, with no stall. Throughput is 1 beat/cycle when out_ready stays high.
- in_ready depends combinationally on out_ready; this is the only combinational in→out path.
- Reset (asynchronous assert, synchronous-release friendly):
  - s1_valid, s2_valid, out_valid = 0; out_sum = 0; out_k = 0.
  - in_ready = 1 on the first cycle after reset.
  - All monitor registers = 0.
- Reset mid-operation discards all in-flight beats; nothing emerges afterwards.
- Full pipeline with out_ready = 0: in_ready = 0. When out_ready rises, in_ready rises in the same cycle and a new beat may enter.

## Configuration
- ERR_MON_EN defined: the monitor ports and logic are compiled in. On each output handshake the monitor computes the error e = a_lo & b_lo, carried through the pipeline, and updates the counters:
  - mon_cnt += 1.
  - mon_nz += (e ≠ 0).
  - mon_err_sum += e.
  - mon_err_sq += e².
  - mon_err_max = max(mon_err_max, e).
  - All accumulators saturate at all-ones.
  - mon_clr synchronously zeroes everything. If it coincides with a handshake, clear wins and that beat is not counted.
  - Monitor outputs update one cycle after the handshake.
- ERR_MON_EN undefined: the monitor ports are absent, with no monitor logic and no extra pipeline state. Datapath behaviour is identical.

## Test plan
- k=2, a=0x000F, b=0x0001, out_ready=1 → out_sum=0x0000F, out_k=2 two cycles later; monitor: cnt=1, nz=1, err_sum=1, err_sq=1, max=1.
- k=0, a=b=0xFFFF → out_sum=0x1FFFE. Then k=4 on the same operands → out_sum=0x1FFEF; monitor err_sum=15, err_sq=225, max=15.
- in_k=7 with APPROX_MAX=4, a=b=0x000F → out_k=4, out_sum=0x0000F.
- Back-to-back stream of 8 beats with out_ready toggled 1,0,0,1,…:
  - out_sum is stable while stalled.
  - in_ready=0 whenever both stages are full and out_ready=0.
  - All 8 results appear in order, matching (a+b)−(a_lo&b_lo).
- Assert rst with 2 beats in flight → out_valid=0 immediately; no beats emerge after release; in_ready=1.
- mon_clr asserted in the same cycle as an output handshake → all mon_* = 0 on the next cycle. Saturation preload check: mon_err_sum stays at 0xFFFFFFFF after a further nonzero-error beat.

Source files
------------

// File: rtl/approx_rca_pipe.sv
// approx_rca_pipe: two-stage pipelined approximate ripple-carry adder with a
// valid/ready handshake.
//   - The low k bit positions (k = min(in_k, APPROX_MAX)) use the approximate
//     cell S = (X|Y)&~Z, Cout = 0. The rest are exact full adders.
//   - Stage 1 adds bits [WIDTH/2-1:0]. Stage 2 adds the upper half and
//     produces the carry-out into the output register.
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   in_valid/in_ready      operand beat handshake (in_a, in_b, in_k)
//   out_valid/out_ready    result beat handshake (out_sum[WIDTH:0], out_k)
//   mon_* (ERR_MON_EN)     error monitor: clear input, count/nonzero/sum/
//                          square/max statistics of e = a_lo & b_lo
// Build option: define ERR_MON_EN to compile in the error monitor.

module approx_fa (
  input  logic x,
  input  logic y,
  input  logic z,
  input  logic approx,
  output logic s,
  output logic co
);
  // The approximate cell never produces a carry, which is what makes the
  // low k bits collapse to a|b when the chain starts with Cz = 0.
  assign s  = approx ? ((x | y) & ~z) : (x ^ y ^ z);
  assign co = approx ? 1'b0 : ((x & y) | (z & (x ^ y)));
endmodule

module approx_rca_pipe #(
  parameter int WIDTH      = 16,
  parameter int APPROX_MAX = 4,
  parameter int KW         = $clog2(APPROX_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [KW-1:0]    in_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [KW-1:0]    out_k
`ifdef ERR_MON_EN
  ,
  input  logic                  mon_clr,
  output logic [31:0]           mon_cnt,
  output logic [31:0]           mon_nz,
  output logic [31:0]           mon_err_sum,
  output logic [47:0]           mon_err_sq,
  output logic [APPROX_MAX-1:0] mon_err_max
`endif
);

  localparam int H  = WIDTH / 2;
  localparam int HU = WIDTH - H;

  typedef struct packed {
    logic [H-1:0]  lo;
    logic          c;
    logic [HU-1:0] a_hi;
    logic [HU-1:0] b_hi;
    logic [KW-1:0] k;
`ifdef ERR_MON_EN
    logic [APPROX_MAX-1:0] e;
`endif
  } s1_t;

  // vld_pipe[1]: stage-1 register full, vld_pipe[2]: output register full
  logic [2:1] vld_pipe;
  logic       s1_adv;
  s1_t        s1_q;

  assign s1_adv    = ~vld_pipe[2] | out_ready;
  assign in_ready  = ~vld_pipe[1] | s1_adv;
  assign out_valid = vld_pipe[2];

  // ---------------- stage 1: low half, approximate cells allowed
  logic [KW-1:0] k_eff;
  logic [H-1:0]  amask;
  logic [H-1:0]  lo_sum;
  logic [H:0]    c1;

  assign k_eff = (in_k > KW'(APPROX_MAX)) ? KW'(APPROX_MAX) : in_k;
  assign c1[0] = 1'b0;

  for (genvar i = 0; i < H; i++) begin : g_lo
    assign amask[i] = (int'(k_eff) > i);
    approx_fa u_fa (
      .x(in_a[i]), .y(in_b[i]), .z(c1[i]), .approx(amask[i]),
      .s(lo_sum[i]), .co(c1[i+1])
    );
  end

  s1_t s1_d;
  always_comb begin
    s1_d      = '0;
    s1_d.lo   = lo_sum;
    s1_d.c    = c1[H];
    s1_d.a_hi = in_a[WIDTH-1:H];
    s1_d.b_hi = in_b[WIDTH-1:H];
    s1_d.k    = k_eff;
`ifdef ERR_MON_EN
    // Error of this beat: the AND terms the approximate cells dropped.
    s1_d.e    = in_a[APPROX_MAX-1:0] & in_b[APPROX_MAX-1:0] & amask[APPROX_MAX-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      s1_q        <= '0;
    end else if (in_ready) begin
      vld_pipe[1] <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // ---------------- stage 2: upper half, always exact
  logic [HU-1:0] hi_sum;
  logic [HU:0]   c2;

  assign c2[0] = s1_q.c;

  for (genvar i = 0; i < HU; i++) begin : g_hi
    approx_fa u_fa (
      .x(s1_q.a_hi[i]), .y(s1_q.b_hi[i]), .z(c2[i]), .approx(1'b0),
      .s(hi_sum[i]), .co(c2[i+1])
    );
  end

`ifdef ERR_MON_EN
  logic [APPROX_MAX-1:0] e2;
`endif

  // Output register only loads on a real beat, so a stalled result holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[2] <= 1'b0;
      out_sum     <= '0;
      out_k       <= '0;
`ifdef ERR_MON_EN
      e2          <= '0;
`endif
    end else if (s1_adv) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        out_sum <= {c2[HU], hi_sum, s1_q.lo};
        out_k   <= s1_q.k;
`ifdef ERR_MON_EN
        e2      <= s1_q.e;
`endif
      end
    end
  end

`ifdef ERR_MON_EN
  // ---------------- error monitor, saturating accumulators
  logic [2*APPROX_MAX-1:0] e_sq;
  logic [32:0]             cnt_n, nz_n, sum_n;
  logic [48:0]             sq_n;

  assign e_sq  = (2*APPROX_MAX)'(e2) * (2*APPROX_MAX)'(e2);
  assign cnt_n = {1'b0, mon_cnt} + 33'd1;
  assign nz_n  = {1'b0, mon_nz} + 33'(e2 != '0);
  assign sum_n = {1'b0, mon_err_sum} + 33'(e2);
  assign sq_n  = {1'b0, mon_err_sq} + 49'(e_sq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_cnt     <= '0;
      mon_nz      <= '0;
      mon_err_sum <= '0;
      mon_err_sq  <= '0;
      mon_err_max <= '0;
    end else if (mon_clr) begin
      // clear takes priority over a coincident output beat
      mon_cnt     <= '0;
      mon_nz      <= '0;
      mon_err_sum <= '0;
      mon_err_sq  <= '0;
      mon_err_max <= '0;
    end else if (out_valid && out_ready) begin
      mon_cnt     <= cnt_n[32] ? '1 : cnt_n[31:0];
      mon_nz      <= nz_n[32]  ? '1 : nz_n[31:0];
      mon_err_sum <= sum_n[32] ? '1 : sum_n[31:0];
      mon_err_sq  <= sq_n[48]  ? '1 : sq_n[47:0];
      if (e2 > mon_err_max) mon_err_max <= e2;
    end
  end
`endif

endmodule
